stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Centisecond stopwatch (SS.cc, 00.00-99.99) placed downstream of the system frequency divider.
//   Consumes the divider's 100 Hz toggling clock level as a count tick, and its 2-bit scan select
//   as the 7-seg digit index. Start/pause/clear/lap FSM runs on a single-cycle command input.
//   Drives a BCD digit plus anode enables to the 7-seg decoder stage.
// PARAMETERS
//   TICK_BOTH_EDGES  0  1: count on both edges of tick_lvl; 0: rising edge only
//   AN_ACTIVE_LOW    1  1: ssd_an / dp_n active-low; 0: active-high (dp_n name kept)
// PORTS
//   clk        in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   tick_lvl   in   1  100 Hz square level from divider, synchronous to clk
//   scan_sel   in   2  digit scan index from divider (0=cs units .. 3=sec tens)
//   btn_start  in   1  1-cycle pulse (debounced upstream): start / pause toggle
//   btn_lap    in   1  1-cycle pulse: lap freeze / release
//   btn_clr    in   1  1-cycle pulse: clear (PAUSE only)
//   running    out  1  1 while state==RUN
//   lap_active out  1  1 while display frozen on lap value
//   ovf        out  1  sticky: count has wrapped 99.99->00.00
//   ssd_bcd    out  4  BCD value of selected digit
//   ssd_an     out  4  one-hot digit enable
//   dp_n       out  1  decimal point, asserted while scan_sel==2
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, count=00.00, lap_reg=00.00, lap_active=0, ovf=0,
//     running=0, tick_d=1, ssd_bcd=0, ssd_an/dp_n deasserted (4'b1111/1 when AN_ACTIVE_LOW).
//     rst mid-count aborts everything; no partial state survives.
//   Tick detect: tick_d <= tick_lvl each cycle; tick_ev = tick_lvl & ~tick_d
//     (or tick_lvl ^ tick_d if TICK_BOTH_EDGES). tick_d reset to 1: high input at reset gives no event.
//   Command priority per cycle: btn_clr > btn_start > btn_lap; lower ones ignored that cycle.
//   FSM (state reg, next-state logic):
//     IDLE : start->RUN. clr, lap ignored.
//     RUN  : start->PAUSE. lap: lap_active=0 -> capture count into lap_reg, set 1; =1 -> clear. clr ignored.
//     PAUSE: start->RUN. clr->IDLE (count, lap_reg, lap_active, ovf all zeroed).
//            lap clears lap_active if set, else ignored.
//   Counting: on tick_ev while current state==RUN, count += 1 (4 BCD digits, each 0-9, ripple carry).
//     Counted even if a start pulse in the same cycle moves RUN->PAUSE.
//     Not counted on IDLE/PAUSE->RUN cycle. Count visible 1 cycle after tick_lvl edge is sampled.
//     99.99 + 1 -> 00.00 and ovf<=1 (sticky until clr or rst).
//   Lap capture takes count value before any same-cycle increment.
//   Display: disp = lap_active ? lap_reg : count. Registered (1-cycle latency from scan_sel):
//     sel0->cs units, sel1->cs tens, sel2->sec units, sel3->sec tens.
//     ssd_an one-hot on bit sel (inverted if AN_ACTIVE_LOW). dp_n asserted only for sel2.
//   running is a registered decode of state (1 iff RUN).
// TESTING
//   rst; start; drive 150 rising tick_lvl edges -> count 01.50, running=1, ovf=0.
//   tick_lvl held high through rst release -> no count until low->high. Start pulse coincides with tick in RUN -> that tick counted, state PAUSE.
//   RUN at 12.34, lap -> lap_active=1, display 12.34 while count advances 50 ticks to 12.84.
//     lap -> display 12.84.
//   Preload via 9999 ticks (99.99), one more tick -> 00.00, ovf=1. pause+clr -> ovf=0, IDLE.
//   clr+start+lap same cycle in PAUSE -> IDLE only. clr in RUN -> ignored, counting continues.
//   scan_sel 0..3 with count 45.67 -> ssd_bcd 7,6,5,4 one cycle later.
//     ssd_an 1110,1101,1011,0111. dp_n=0 only for sel 2.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Centisecond stopwatch (SS.cc) driven by the divider's 100 Hz level and scan index.
// Start/pause/clear/lap control with a registered 7-segment digit/anode output stage.
module stopwatch_ctrl #(
    parameter bit TICK_BOTH_EDGES = 1'b0,
    parameter bit AN_ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_lvl,
    input  logic [1:0] scan_sel,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic       running,
    output logic       lap_active,
    output logic       ovf,
    output logic [3:0] ssd_bcd,
    output logic [3:0] ssd_an,
    output logic       dp_n
);

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DIGITS-1:0][DIGIT_W-1:0] count, count_nxt, count_inc;
    logic [DIGITS-1:0][DIGIT_W-1:0] lap_reg, lap_nxt, disp;
    logic                           lap_active_nxt, ovf_nxt;
    logic                           tick_d, tick_ev, wrap;
    logic [DIGIT_W-1:0]             digit;
    logic [3:0]                     an_onehot;
    logic                           dp_on;

    always_comb begin
        tick_ev = TICK_BOTH_EDGES ? (tick_lvl ^ tick_d) : (tick_lvl & ~tick_d);
    end

    // BCD ripple increment; wrap is the carry out of the seconds-tens digit
    always_comb begin
        count_inc = count;
        wrap      = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (wrap) begin
                if (count[i] == DIGIT_W'(9)) begin
                    count_inc[i] = '0;
                end else begin
                    count_inc[i] = count[i] + DIGIT_W'(1);
                    wrap         = 1'b0;
                end
            end
        end
    end

    // Next-state and datapath updates; btn_clr > btn_start > btn_lap
    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        lap_nxt        = lap_reg;
        lap_active_nxt = lap_active;
        ovf_nxt        = ovf;
        case (state)
            S_IDLE: begin
                if (!btn_clr && btn_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!btn_clr) begin
                    if (btn_start) begin
                        state_nxt = S_PAUSE;
                    end else if (btn_lap) begin
                        if (lap_active) begin
                            lap_active_nxt = 1'b0;
                        end else begin
                            lap_nxt        = count;
                            lap_active_nxt = 1'b1;
                        end
                    end
                end
                // The tick still counts on the cycle a start pulse pauses the watch
                if (tick_ev) begin
                    count_nxt = count_inc;
                    if (wrap) begin
                        ovf_nxt = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (btn_clr) begin
                    state_nxt      = S_IDLE;
                    count_nxt      = '0;
                    lap_nxt        = '0;
                    lap_active_nxt = 1'b0;
                    ovf_nxt        = 1'b0;
                end else if (btn_start) begin
                    state_nxt = S_RUN;
                end else if (btn_lap) begin
                    lap_active_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        disp      = lap_active ? lap_reg : count;
        digit     = disp[scan_sel];
        an_onehot = 4'b0001 << scan_sel;
        dp_on     = (scan_sel == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            lap_reg    <= '0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
            tick_d     <= 1'b1;
            running    <= 1'b0;
            ssd_bcd    <= '0;
            ssd_an     <= AN_ACTIVE_LOW ? 4'b1111 : 4'b0000;
            dp_n       <= AN_ACTIVE_LOW;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            lap_reg    <= lap_nxt;
            lap_active <= lap_active_nxt;
            ovf        <= ovf_nxt;
            tick_d     <= tick_lvl;
            running    <= (state_nxt == S_RUN);
            ssd_bcd    <= digit;
            ssd_an     <= AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
            dp_n       <= AN_ACTIVE_LOW ? ~dp_on : dp_on;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: an integer-level model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick_lvl, btn_start, btn_lap, btn_clr;
    logic [1:0] scan_sel;
    logic       running, lap_active, ovf, dp_n;
    logic [3:0] ssd_bcd, ssd_an;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_lvl   (tick_lvl),
        .scan_sel   (scan_sel),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .btn_clr    (btn_clr),
        .running    (running),
        .lap_active (lap_active),
        .ovf        (ovf),
        .ssd_bcd    (ssd_bcd),
        .ssd_an     (ssd_an),
        .dp_n       (dp_n)
    );

    typedef struct packed {
        logic       running;
        logic       lap_active;
        logic       ovf;
        logic [3:0] bcd;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: values as plain integers 0..9999, states as 0=idle 1=run 2=pause
    int m_state = 0, m_cnt = 0, m_lap = 0;
    bit m_lapact = 0, m_ovf = 0, m_tickd = 1;
    exp_t m_out;
    int p10[4] = '{1, 10, 100, 1000};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("running",    int'(running),    int'(e.running));
            check("lap_active", int'(lap_active), int'(e.lap_active));
            check("ovf",        int'(ovf),        int'(e.ovf));
            check("ssd_bcd",    int'(ssd_bcd),    int'(e.bcd));
            check("ssd_an",     int'(ssd_an),     int'(e.an));
            check("dp_n",       int'(dp_n),       int'(e.dp));
        end
    end

    task automatic model(input bit r, input bit t, input int sel, input bit s, input bit l, input bit c);
        int disp;
        bit ev;
        if (r) begin
            m_state = 0; m_cnt = 0; m_lap = 0; m_lapact = 0; m_ovf = 0; m_tickd = 1;
            m_out = '{running: 1'b0, lap_active: 1'b0, ovf: 1'b0, bcd: 4'd0, an: 4'hF, dp: 1'b1};
            return;
        end
        disp    = m_lapact ? m_lap : m_cnt;
        ev      = t && !m_tickd;
        m_tickd = t;
        m_out.bcd = 4'((disp / p10[sel]) % 10);
        m_out.an  = 4'hF & ~(4'd1 << sel);
        m_out.dp  = (sel != 2);
        if (c) begin
            if (m_state == 2) begin
                m_state = 0; m_cnt = 0; m_lap = 0; m_lapact = 0; m_ovf = 0;
            end
        end else if (s) begin
            m_state = (m_state == 1) ? 2 : 1;
            if (ev && m_state == 2) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 10000) begin m_cnt = 0; m_ovf = 1; end
            end
            ev = 0;
        end else if (l) begin
            if (m_state == 1) begin
                if (m_lapact) m_lapact = 0;
                else begin m_lap = m_cnt; m_lapact = 1; end
            end else if (m_state == 2) begin
                m_lapact = 0;
            end
        end
        if (ev && m_state == 1) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 10000) begin m_cnt = 0; m_ovf = 1; end
        end
        m_out.running    = (m_state == 1);
        m_out.lap_active = m_lapact;
        m_out.ovf        = m_ovf;
    endtask

    task automatic step(input bit r, input bit t, input int sel, input bit s, input bit l, input bit c);
        rst = r; tick_lvl = t; scan_sel = 2'(sel); btn_start = s; btn_lap = l; btn_clr = c;
        model(r, t, sel, s, l, c);
        @(posedge clk);
        exp_q.push_back(m_out);
        #1;
    endtask

    function automatic int rsel();
        return int'($urandom_range(0, 3));
    endfunction

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, rsel(), 0, 0, 0);
            step(0, 0, rsel(), 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        step(1, 0, rsel(), 0, 0, 0);
        step(1, 0, rsel(), 0, 0, 0);
    endtask

    initial begin
        // Basic counting to 01.50
        do_reset();
        step(0, 0, rsel(), 1, 0, 0);
        ticks(150);
        for (int i = 0; i < 4; i++) step(0, 0, i, 0, 0, 0);

        // tick held high through reset release, then start coinciding with a tick
        step(1, 1, rsel(), 0, 0, 0);
        step(1, 1, rsel(), 0, 0, 0);
        step(0, 1, rsel(), 1, 0, 0);
        step(0, 1, rsel(), 0, 0, 0);
        ticks(3);
        step(0, 1, rsel(), 1, 0, 0);
        step(0, 0, rsel(), 0, 0, 0);
        ticks(2);
        for (int i = 0; i < 4; i++) step(0, 0, i, 0, 0, 0);

        // Lap freeze at 12.34 while the count advances to 12.84
        do_reset();
        step(0, 0, rsel(), 1, 0, 0);
        ticks(1234);
        step(0, 0, rsel(), 0, 1, 0);
        ticks(50);
        for (int i = 0; i < 4; i++) step(0, 0, i, 0, 0, 0);
        step(0, 0, rsel(), 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, i, 0, 0, 0);

        // Wrap 99.99 -> 00.00 with sticky ovf, then pause + clear
        do_reset();
        step(0, 0, rsel(), 1, 0, 0);
        ticks(9999);
        for (int i = 0; i < 4; i++) step(0, 0, i, 0, 0, 0);
        ticks(1);
        ticks(2);
        step(0, 0, rsel(), 1, 0, 0);
        step(0, 0, rsel(), 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, i, 0, 0, 0);

        // clr+start+lap together in PAUSE; clr in RUN is ignored
        step(0, 0, rsel(), 1, 0, 0);
        ticks(7);
        step(0, 0, rsel(), 0, 1, 0);
        step(0, 0, rsel(), 1, 0, 0);
        step(0, 0, rsel(), 1, 1, 1);
        step(0, 0, rsel(), 0, 0, 0);
        step(0, 0, rsel(), 1, 0, 0);
        step(0, 0, rsel(), 0, 0, 1);
        ticks(5);
        step(0, 1, rsel(), 0, 0, 1);
        step(0, 0, rsel(), 0, 0, 0);

        // Digit scan with 45.67 displayed
        do_reset();
        step(0, 0, rsel(), 1, 0, 0);
        ticks(4567);
        step(0, 0, rsel(), 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, i, 0, 0, 0);
        for (int i = 3; i >= 0; i--) step(0, 0, i, 0, 0, 0);

        // Randomized commands and tick levels
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), rsel(),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0);
        end

        begin
            int waited = 0;
            while (exp_q.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            @(negedge clk);
            #1;
            check("scoreboard_drained", exp_q.size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
